// File: rtl/bus_sync_arb_pkg.sv
// Shared definitions for bus_sync_arb: FSM state encoding, a constant clog2,
// and the width of the bundle {data, id, toggle} fed to one bus_sync_sf.
// Ports: none (package).
package bus_sync_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HOLD = 2'd1,
    ARB_ACK  = 2'd2
  } arb_state_t;

  // Ceiling log2 usable in parameter/localparam expressions.
  function automatic int bsa_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width of the bus_sync_sf data_in this arbiter drives: word + tag + toggle.
  function automatic int bundle_width(input int data_w, input int id_w);
    return data_w + id_w + 1;
  endfunction

endpackage

// File: rtl/bus_sync_arb_pick.sv
// Combinational winner selector for bus_sync_arb.
// Ports: req (request levels), ptr (round-robin start index) -> win (index), any (some req set).
// Build option BUS_SYNC_ARB_RR_EN: round-robin from ptr; otherwise lowest set index wins.
module bus_sync_arb_pick
  import bus_sync_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  win,
  output logic            any
);

  assign any = |req;

`ifdef BUS_SYNC_ARB_RR_EN
  // Rotate req so that bit 0 of w_rot is requester ptr; the lowest set bit of
  // the rotated vector is the first requester at or after ptr (with wrap).
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;

  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[NREQ-1:0];

  always_comb begin
    int s;
    s   = 0;
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        s = int'(ptr) + k;
        if (s >= NREQ) s = s - NREQ;
        win = IDW'(s);
      end
    end
  end
`else
  // Fixed priority has no use for the pointer.
  logic w_unused_ptr;
  assign w_unused_ptr = ^ptr;

  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win = IDW'(i);
    end
  end
`endif

endmodule

// File: rtl/bus_sync_arb.sv
// Time-multiplexes one bus_sync_sf between NREQ requesters: latches a winner's word,
// holds {sync_data, sync_id, sync_tgl} stable for HOLD cycles, then pulses ack[w].
// Ports: NCLK2/RST (sync, active-low), req/req_data in; ack, busy, sync_data/id/tgl out (all registered).
// Build option BUS_SYNC_ARB_RR_EN: round-robin arbitration with a pointer; default fixed priority.
module bus_sync_arb
  import bus_sync_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int sword = 32,
  parameter int IDW   = 2,
  parameter int HOLD  = 8
) (
  input  logic                  NCLK2,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*sword-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic [sword-1:0]      sync_data,
  output logic [IDW-1:0]        sync_id,
  output logic                  sync_tgl
);

  localparam int CW = bsa_clog2(HOLD) + 1;

  arb_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [IDW-1:0]   r_win, w_win_nxt;
  logic [NREQ-1:0]  r_ack, w_ack_nxt;
  logic             r_busy;
  logic [sword-1:0] r_sync_data, w_data_nxt;
  logic [IDW-1:0]   r_sync_id, w_id_nxt;
  logic             r_sync_tgl, w_tgl_nxt;

  logic [IDW-1:0]   w_pick;
  logic             w_any;
  logic [IDW-1:0]   w_pick_ptr;
  logic [sword-1:0] w_word;

`ifdef BUS_SYNC_ARB_RR_EN
  logic [IDW-1:0] r_ptr, w_ptr_nxt;
  assign w_pick_ptr = r_ptr;
`else
  assign w_pick_ptr = '0;
`endif

  bus_sync_arb_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req (req),
    .ptr (w_pick_ptr),
    .win (w_pick),
    .any (w_any)
  );

  // Word of the current winner.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == IDW'(i)) w_word = req_data[i*sword +: sword];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_win_nxt   = r_win;
    w_ack_nxt   = '0;
    w_data_nxt  = r_sync_data;
    w_id_nxt    = r_sync_id;
    w_tgl_nxt   = r_sync_tgl;
`ifdef BUS_SYNC_ARB_RR_EN
    w_ptr_nxt   = r_ptr;
`endif
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_data_nxt  = w_word;
          w_id_nxt    = w_pick;
          w_tgl_nxt   = ~r_sync_tgl;
          w_cnt_nxt   = CW'(HOLD - 1);
          w_win_nxt   = w_pick;
          w_state_nxt = ARB_HOLD;
        end
      end
      ARB_HOLD: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_ack_nxt   = NREQ'(1) << r_win;
          w_state_nxt = ARB_ACK;
        end
      end
      ARB_ACK: begin
        // Requester drops req or presents its next word during this cycle.
`ifdef BUS_SYNC_ARB_RR_EN
        w_ptr_nxt = (r_win == IDW'(NREQ - 1)) ? '0 : r_win + IDW'(1);
`endif
        w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge NCLK2) begin
    if (!RST) begin
      r_state     <= ARB_IDLE;
      r_cnt       <= '0;
      r_win       <= '0;
      r_ack       <= '0;
      r_busy      <= 1'b0;
      r_sync_data <= '0;
      r_sync_id   <= '0;
      r_sync_tgl  <= 1'b0;
`ifdef BUS_SYNC_ARB_RR_EN
      r_ptr       <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_win       <= w_win_nxt;
      r_ack       <= w_ack_nxt;
      r_busy      <= (w_state_nxt != ARB_IDLE);
      r_sync_data <= w_data_nxt;
      r_sync_id   <= w_id_nxt;
      r_sync_tgl  <= w_tgl_nxt;
`ifdef BUS_SYNC_ARB_RR_EN
      r_ptr       <= w_ptr_nxt;
`endif
    end
  end

  assign ack       = r_ack;
  assign busy      = r_busy;
  assign sync_data = r_sync_data;
  assign sync_id   = r_sync_id;
  assign sync_tgl  = r_sync_tgl;

endmodule

// File: tb/tb_bus_sync_arb.sv
// Self-checking bench for bus_sync_arb (NREQ=4, sword=32, IDW=2, HOLD=4).
// Expected grants are queued when stimulus is applied and popped on each sync_tgl edge.
// Works with and without BUS_SYNC_ARB_RR_EN.
module tb_bus_sync_arb;

  localparam int NREQ = 4;
  localparam int SW   = 32;
  localparam int IDW  = 2;
  localparam int HOLD = 4;
  localparam int PER  = HOLD + 2;

  logic                 NCLK2 = 1'b0;
  logic                 RST;
  logic [NREQ-1:0]      req;
  logic [NREQ*SW-1:0]   req_data;
  logic [NREQ-1:0]      ack;
  logic                 busy;
  logic [SW-1:0]        sync_data;
  logic [IDW-1:0]       sync_id;
  logic                 sync_tgl;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] words[NREQ];

  bus_sync_arb #(
    .NREQ  (NREQ),
    .sword (SW),
    .IDW   (IDW),
    .HOLD  (HOLD)
  ) dut (
    .NCLK2     (NCLK2),
    .RST       (RST),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .busy      (busy),
    .sync_data (sync_data),
    .sync_id   (sync_id),
    .sync_tgl  (sync_tgl)
  );

  always #5 NCLK2 = ~NCLK2;

  task automatic set_words(input logic [31:0] base);
    for (int i = 0; i < NREQ; i++) begin
      words[i] = base + 32'(i);
      req_data[i*SW +: SW] = base + 32'(i);
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    req = '0;
    exp_q.delete();
    repeat (2) @(negedge NCLK2);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    req = 4'b1111;
    set_words(32'h1000_0000);
    for (int c = 1; c <= 3; c++) begin
      @(negedge NCLK2);
      checks++;
      if ({ack, busy, sync_data, sync_id, sync_tgl} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d ack=%b busy=%b data=%h id=%0d tgl=%b required all zero",
                 c, ack, busy, sync_data, sync_id, sync_tgl);
      end
    end
    RST = 1'b1;
    @(negedge NCLK2);
    checks++;
    if (busy !== 1'b1 || sync_id !== 2'd0 || sync_data !== words[0] || sync_tgl !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant busy=%b id=%0d data=%h tgl=%b required 1/0/%h/1",
               busy, sync_id, sync_data, sync_tgl, words[0]);
    end
  endtask

  task automatic test_single();
    logic prev_tgl, exp_tgl;
    exp_t e;
    do_reset();
    set_words(32'hA5A5_0001);
    req = 4'b0001;
    exp_q.push_back('{0, words[0], 1});
    prev_tgl = 1'b0;
    exp_tgl  = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge NCLK2);
      checks++;
      if (busy !== (c >= 1 && c <= 5)) begin
        failures++;
        $display("FAIL single_busy cycle=%0d busy=%b required %b", c, busy, (c >= 1 && c <= 5));
      end
      checks++;
      if (ack !== ((c == 5) ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL single_ack cycle=%0d ack=%b required %b", c, ack, (c == 5) ? 4'b0001 : 4'b0000);
      end
      if (sync_tgl !== prev_tgl) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL single_unexpected_word cycle=%0d id=%0d", c, sync_id);
        end else begin
          e = exp_q.pop_front();
          exp_tgl = ~exp_tgl;
          if (sync_id !== IDW'(e.id) || sync_data !== e.data || sync_tgl !== exp_tgl || c != e.cyc) begin
            failures++;
            $display("FAIL single_word cycle=%0d id=%0d data=%h tgl=%b required cycle=%0d id=%0d data=%h tgl=%b",
                     c, sync_id, sync_data, sync_tgl, e.cyc, e.id, e.data, exp_tgl);
          end
        end
      end
      prev_tgl = sync_tgl;
      if (c == 5) req = 4'b0000;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_missing_words left=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_drop();
    logic prev_tgl, exp_tgl;
    exp_t e;
    do_reset();
    set_words(32'hD0D0_0000);
    req = 4'b0100;
    exp_q.push_back('{2, words[2], 1});
    prev_tgl = 1'b0;
    exp_tgl  = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge NCLK2);
      checks++;
      if (ack !== ((c == 5) ? 4'b0100 : 4'b0000)) begin
        failures++;
        $display("FAIL drop_ack cycle=%0d ack=%b required %b", c, ack, (c == 5) ? 4'b0100 : 4'b0000);
      end
      checks++;
      if (busy !== (c <= 5)) begin
        failures++;
        $display("FAIL drop_busy cycle=%0d busy=%b required %b", c, busy, (c <= 5));
      end
      if (sync_tgl !== prev_tgl) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL drop_unexpected_word cycle=%0d id=%0d", c, sync_id);
        end else begin
          e = exp_q.pop_front();
          exp_tgl = ~exp_tgl;
          if (sync_id !== IDW'(e.id) || sync_data !== e.data || sync_tgl !== exp_tgl || c != e.cyc) begin
            failures++;
            $display("FAIL drop_word cycle=%0d id=%0d data=%h required cycle=%0d id=%0d data=%h",
                     c, sync_id, sync_data, e.cyc, e.id, e.data);
          end
        end
      end
      prev_tgl = sync_tgl;
      if (c == 2) begin
        req = 4'b0000;
        req_data[2*SW +: SW] = 32'hDEAD_BEEF;
      end
    end
    checks++;
    if (sync_data !== words[2] || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drop_final data=%h left=%0d required %h 0", sync_data, exp_q.size(), words[2]);
    end
  endtask

  task automatic test_reset_mid();
    logic prev_tgl, exp_tgl;
    logic exp_busy;
    exp_t e;
    do_reset();
    set_words(32'h5EED_0000);
    req = 4'b0010;
    exp_q.push_back('{1, words[1], 1});
    exp_q.push_back('{1, words[1], 5});
    prev_tgl = 1'b0;
    exp_tgl  = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge NCLK2);
      if (c == 4) begin
        checks++;
        if ({ack, busy, sync_data, sync_id, sync_tgl} !== '0) begin
          failures++;
          $display("FAIL midreset_outputs ack=%b busy=%b data=%h id=%0d tgl=%b required all zero",
                   ack, busy, sync_data, sync_id, sync_tgl);
        end
        exp_tgl = 1'b0;
        RST = 1'b1;
      end else begin
        exp_busy = (c <= 3) || (c >= 5 && c <= 9);
        checks++;
        if (busy !== exp_busy || ack !== ((c == 9) ? 4'b0010 : 4'b0000)) begin
          failures++;
          $display("FAIL midreset_busy_ack cycle=%0d busy=%b ack=%b required %b %b",
                   c, busy, ack, exp_busy, (c == 9) ? 4'b0010 : 4'b0000);
        end
        if (sync_tgl !== prev_tgl) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL midreset_unexpected_word cycle=%0d id=%0d", c, sync_id);
          end else begin
            e = exp_q.pop_front();
            exp_tgl = ~exp_tgl;
            if (sync_id !== IDW'(e.id) || sync_data !== e.data || sync_tgl !== exp_tgl || c != e.cyc) begin
              failures++;
              $display("FAIL midreset_word cycle=%0d id=%0d tgl=%b required cycle=%0d id=%0d tgl=%b",
                       c, sync_id, sync_tgl, e.cyc, e.id, exp_tgl);
            end
          end
        end
      end
      prev_tgl = sync_tgl;
      if (c == 3) RST = 1'b0;
      if (c == 9) req = 4'b0000;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_missing_words left=%0d required 0", exp_q.size());
    end
  endtask

  // Continuous requests: the bench's own arbitration model predicts the grant order.
  task automatic test_stream(input string name, input logic [3:0] mask, input int n);
    logic prev_tgl, exp_tgl;
    logic [3:0] exp_ack;
    int ptr, w, last_id;
    exp_t e;
    do_reset();
    set_words(32'hC0DE_0000);
    req = mask;
    ptr = 0;
    for (int k = 0; k < n; k++) begin
      w = -1;
`ifdef BUS_SYNC_ARB_RR_EN
      for (int j = 0; j < NREQ; j++) begin
        if (w < 0 && mask[(ptr + j) % NREQ]) w = (ptr + j) % NREQ;
      end
      ptr = (w + 1) % NREQ;
`else
      for (int j = NREQ - 1; j >= 0; j--) begin
        if (mask[j]) w = j;
      end
`endif
      exp_q.push_back('{w, words[w], 1 + PER * k});
    end
    prev_tgl = 1'b0;
    exp_tgl  = 1'b0;
    last_id  = 0;
    for (int c = 1; c <= PER * n; c++) begin
      @(negedge NCLK2);
      if (sync_tgl !== prev_tgl) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s unexpected_word cycle=%0d id=%0d", name, c, sync_id);
        end else begin
          e = exp_q.pop_front();
          exp_tgl = ~exp_tgl;
          last_id = e.id;
          if (sync_id !== IDW'(e.id) || sync_data !== e.data || sync_tgl !== exp_tgl || c != e.cyc) begin
            failures++;
            $display("FAIL %s word cycle=%0d id=%0d data=%h tgl=%b required cycle=%0d id=%0d data=%h tgl=%b",
                     name, c, sync_id, sync_data, sync_tgl, e.cyc, e.id, e.data, exp_tgl);
          end
        end
      end
      prev_tgl = sync_tgl;
      exp_ack = ((c % PER) == HOLD + 1) ? (4'b0001 << last_id) : 4'b0000;
      checks++;
      if (ack !== exp_ack || busy !== ((c % PER) != 0)) begin
        failures++;
        $display("FAIL %s ack_busy cycle=%0d ack=%b busy=%b required %b %b",
                 name, c, ack, busy, exp_ack, ((c % PER) != 0));
      end
    end
    req = '0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_words left=%0d required 0", name, exp_q.size());
    end
  endtask

  initial begin
    RST      = 1'b0;
    req      = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_drop();
    test_reset_mid();
    test_stream("contention", 4'b1111, 5);
    test_stream("wrap", 4'b1001, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_sync_arb.md
# bus_sync_arb

Time-multiplexes one shared clock-domain bus synchroniser (`bus_sync_sf`) between `NREQ` requesters in the `NCLK2` domain. It latches one requester's word, drives it together with a requester tag and a toggle-valid bit onto the synchroniser input, and holds that bundle stable for `HOLD` cycles so the far domain captures it cleanly. It then acknowledges the requester and moves on. It sits between the local requesters and the `data_in` of one `bus_sync_sf` instance whose width is `sword + IDW + 1`.

## Interface

- `NREQ`, 4, number of requesters (2..16).
- `sword`, 32, data word width.
- `IDW`, 2, requester-id width; must be ≥ clog2(`NREQ`).
- `HOLD`, 8, cycles each word is held before ack (≥ 1).
- `NCLK2`, in, 1, clock, rising edge.
- `RST`, in, 1, reset, synchronous, active-low.
- `req`, in, `NREQ`, level request per requester.
- `req_data`, in, `NREQ*sword`, requester i word at `[i*sword +: sword]`.
- `ack`, out, `NREQ`, one-hot single-cycle pulse: word of requester i transferred.
- `busy`, out, 1, high whenever state ≠ IDLE.
- `sync_data`, out, `sword`, latched word to the synchroniser.
- `sync_id`, out, `IDW`, index of the requester owning `sync_data`.
- `sync_tgl`, out, 1, inverts on every new word; the receiver detects new words on its edges.

## Operation

- **Reset values:** state IDLE; `ack`, `busy`, `sync_data`, `sync_id` and `sync_tgl` all 0; round-robin pointer 0; hold counter 0.
- **FSM states:** IDLE, HOLD, ACK.
- **IDLE:**
  - If `req` == 0, stay in IDLE.
  - Otherwise pick winner w and register:
    - `sync_data` ← word w
    - `sync_id` ← w
    - `sync_tgl` ← ~`sync_tgl`
    - cnt ← `HOLD`-1
    - remember w
  - Go to HOLD.
- **HOLD:**
  - If cnt ≠ 0, decrement it.
  - If cnt == 0, register `ack[w]` ← 1 and go to ACK.
- **ACK:**
  - `ack[w]` is high for exactly this cycle.
  - `ack` is cleared on exit.
  - Pointer ← (w+1) mod `NREQ`.
  - Go to IDLE. No arbitration happens in ACK; the requester uses this cycle to drop `req` or present its next word.
- **Requests during a transfer:** `req` and `req_data` changes during HOLD/ACK are ignored because the word is already latched. If `req[w]` drops mid-transfer, the transfer still completes and `ack[w]` still pulses.
- **Winner selection:** see Configuration. Requesters with `req` low are never granted.
- **Counter width:** clog2(`HOLD`)+1 bits; no wrap occurs.
- **`sync_tgl` wrap:** wraps freely; only its edges carry meaning.

## Timing

- `req` sampled in IDLE at cycle 0 → `sync_*` updated and `busy`=1 from cycle 1.
- HOLD occupies cycles 1..`HOLD`.
- `ack[w]` is high in cycle `HOLD`+1 (the ACK state).
- IDLE is re-entered at cycle `HOLD`+2.
- Per-word period is `HOLD`+2 cycles; the `sync_*` bundle is stable for at least that long.
- `HOLD` is sized by integration to cover ≥3 periods of the slower clock of the `bus_sync_sf` pair.
- **Reset mid-operation:** on the next edge all outputs return to reset values. The transfer is aborted with no ack; the receiver is reset by the same `RST`.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration

- `BUS_SYNC_ARB_RR_EN` defined:
  - Round-robin selection: search starts at the pointer and wraps at `NREQ`-1 → 0.
  - The pointer advances in ACK to (w+1) mod `NREQ`.
- Undefined:
  - Fixed priority: the lowest set index of `req` wins.
  - The pointer register is not built.

## Structure

- **Shared package `bus_sync_arb_pkg`:**
  - state encoding constants `ARB_IDLE`=2'd0, `ARB_HOLD`=2'd1, `ARB_ACK`=2'd2
  - a clog2 function
  - the bundle width `sword+IDW+1` helper
- **Sub-module `bus_sync_arb_pick`:** combinational winner selector.
  - Inputs: `req`, pointer.
  - Outputs: winner index and `any`.
  - Contains both the round-robin and fixed-priority variants under the macro.
- The FSM, counter and registers live in the top module.

## Test plan

1. **Reset:** `RST`=0 for 3 cycles with `req`=4'b1111 → all outputs 0, `busy`=0, no `ack`; after release the first grant goes to 0.
2. **Single request:** `HOLD`=4; `req`=4'b0001, word0=32'hA5A5_0001 at cycle 0.
   - Cycle 1: `sync_data`=32'hA5A50001, `sync_id`=0, `sync_tgl`=1.
   - `ack`=4'b0001 only at cycle 5.
   - `busy` high for cycles 1..5.
3. **Contention:** `req`=4'b1111 held, `HOLD`=4.
   - With `BUS_SYNC_ARB_RR_EN`: `sync_id` sequence 0,1,2,3,0 every 6 cycles.
   - Without the macro: 0,0,0.
   - `sync_tgl` alternates on each word.
4. **Drop mid-hold:** `req[2]` alone, dropped at cycle 2 → `ack[2]` still pulses at cycle 5; IDLE at cycle 6 with no new grant.
5. **Reset mid-HOLD:** `RST`=0 at cycle 3 → cycle 4 shows all outputs 0 and no ack; `req[1]` still high → re-granted 1 cycle after release.
6. **Wrap (RR):** `req`=4'b1001 → grants alternate 0,3,0,3; the pointer wraps from 3 to 0.
